// File: rtl/grey_init_loader.sv
// Assembles the grey counter's INIT preset word from a digit-serial pin stream.
// Each digit is validated as a Johnson code, and o_load pulses once the word is complete.
module grey_init_loader #(
  parameter int DIGITS      = 12,
  parameter int DW          = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_stb,
  input  logic [DW-1:0]        i_sym,
  output logic [DIGITS*DW-1:0] o_init,
  output logic                 o_load,
  output logic                 o_busy,
  output logic                 o_err,
  output logic [3:0]           o_count
);

  localparam int WW = DIGITS * DW;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, ERR} state_t;

  state_t                        state_q, state_d;
  logic [SYNC_STAGES-1:0]        start_sync_q, start_sync_d;
  logic [SYNC_STAGES-1:0]        stb_sync_q, stb_sync_d;
  logic [SYNC_STAGES-1:0][DW-1:0] sym_sync_q, sym_sync_d;
  logic                          start_last_q, start_last_d;
  logic                          stb_last_q, stb_last_d;
  logic [WW-1:0]                 shift_q, shift_d;
  logic [WW-1:0]                 init_q, init_d;
  logic                          load_q, load_d;
  logic                          busy_q, busy_d;
  logic                          err_q, err_d;
  logic [3:0]                    count_q, count_d;

  logic          start_edge, stb_edge;
  logic [DW-1:0] sym_s;

  function automatic logic johnson_valid(input logic [DW-1:0] s);
    case (s)
      5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
      5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000: johnson_valid = 1'b1;
      default:                                          johnson_valid = 1'b0;
    endcase
  endfunction

  // Sym travels through the same depth as stb, so the captured symbol lines up with its strobe edge.
  always_comb begin
    start_sync_d = {start_sync_q[SYNC_STAGES-2:0], i_start};
    stb_sync_d   = {stb_sync_q[SYNC_STAGES-2:0], i_stb};
    sym_sync_d   = {sym_sync_q[SYNC_STAGES-2:0], i_sym};
    start_last_d = start_sync_q[SYNC_STAGES-1];
    stb_last_d   = stb_sync_q[SYNC_STAGES-1];
  end

  assign start_edge = start_sync_q[SYNC_STAGES-1] & ~start_last_q;
  assign stb_edge   = stb_sync_q[SYNC_STAGES-1] & ~stb_last_q;
  assign sym_s      = sym_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    init_d  = init_q;
    load_d  = 1'b0;
    busy_d  = busy_q;
    err_d   = err_q;
    count_d = count_q;
    case (state_q)
      IDLE, ERR: begin
        if (start_edge) begin
          state_d = SHIFT;
          shift_d = '0;
          count_d = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      SHIFT: begin
        // A start edge overrides a strobe seen on the same clock.
        if (start_edge) begin
          shift_d = '0;
          count_d = '0;
        end else if (stb_edge) begin
          if (johnson_valid(sym_s)) begin
            shift_d = {shift_q[WW-DW-1:0], sym_s};
            if (count_q < 4'(DIGITS)) count_d = count_q + 4'd1;
            if (count_q == 4'(DIGITS - 1)) state_d = LOAD;
          end else begin
            state_d = ERR;
            busy_d  = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      LOAD: begin
        init_d  = shift_q;
        load_d  = 1'b1;
        busy_d  = 1'b0;
        count_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      start_sync_q <= '0;
      stb_sync_q   <= '0;
      sym_sync_q   <= '0;
      start_last_q <= 1'b0;
      stb_last_q   <= 1'b0;
      shift_q      <= '0;
      init_q       <= '0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      start_sync_q <= start_sync_d;
      stb_sync_q   <= stb_sync_d;
      sym_sync_q   <= sym_sync_d;
      start_last_q <= start_last_d;
      stb_last_q   <= stb_last_d;
      shift_q      <= shift_d;
      init_q       <= init_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      count_q      <= count_d;
    end
  end

  assign o_init  = init_q;
  assign o_load  = load_q;
  assign o_busy  = busy_q;
  assign o_err   = err_q;
  assign o_count = count_q;

endmodule
